cache_replace_policy: RTL and testbench

//  Per-set replacement-state keeper for the set-associative data cache. Tracks recency for

---
 rtl/cache_replace_policy_if.sv | 28 ++
 rtl/cache_replace_policy.sv | 175 +++++++++++++++++
 tb/tb_cache_replace_policy.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/cache_replace_policy_if.sv
// Access-side bundle between the D-cache controller and the replacement-state keeper.
// The controller drives the access lines; the keeper answers with victim/ready/err.
interface cache_replace_policy_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int WAYS       = 4
);
   localparam int WW = $clog2(WAYS);

   logic [ADDR_WIDTH-1:0] addr_i;
   logic [WAYS-1:0]       valid_i;
   logic [WW-1:0]         current_way_i;
   logic                  hit_i;
   logic                  miss_i;
   logic                  flush_i;
   logic [WW-1:0]         victim_o;
   logic                  ready_o;
   logic                  err_o;

   modport master (
      output addr_i, valid_i, current_way_i, hit_i, miss_i, flush_i,
      input  victim_o, ready_o, err_o
   );

   modport slave (
      input  addr_i, valid_i, current_way_i, hit_i, miss_i, flush_i,
      output victim_o, ready_o, err_o
   );
endinterface

// File: rtl/cache_replace_policy.sv
// Per-set replacement state for the set-associative D-cache: true-LRU age counters
// (MODE=0) or tree-PLRU (MODE=1), with invalid-way preference and a sweeping init/flush.
module cache_replace_policy #(
   parameter int WAYS       = 4,
   parameter int CACHE_SIZE = 32768,
   parameter int BLOCK_SIZE = 16,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MODE       = 0
) (
   input logic                   clock,
   input logic                   rst_n,
   cache_replace_policy_if.slave bus
);
   localparam int SETS   = CACHE_SIZE / (BLOCK_SIZE * WAYS);
   localparam int IDX    = $clog2(SETS);
   localparam int WW     = $clog2(WAYS);
   localparam int OFFSET = $clog2(BLOCK_SIZE);
   localparam logic [IDX-1:0] LAST_SET = IDX'(SETS - 1);
   localparam int unused_data_width = DATA_WIDTH;

   typedef enum logic [1:0] {S_INIT, S_IDLE, S_FLUSH} state_t;

   state_t         state_q, state_d;
   logic [IDX-1:0] cnt_q, cnt_d;
   logic           err_q, err_d;
   logic           sweep_we;
   logic           acc_we;
   logic [IDX-1:0] set_idx;
   logic [WW-1:0]  pol_victim;
   logic [WW-1:0]  victim_sel;
   logic [WW-1:0]  touch_way;
   logic           unused_addr;

   assign set_idx     = bus.addr_i[OFFSET+IDX-1:OFFSET];
   assign unused_addr = ^{bus.addr_i[ADDR_WIDTH-1:OFFSET+IDX], bus.addr_i[OFFSET-1:0]};

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Sweep one set per edge during INIT/FLUSH; accesses only take effect in IDLE.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      err_d    = 1'b0;
      sweep_we = 1'b0;
      acc_we   = 1'b0;
      unique case (state_q)
         S_INIT, S_FLUSH: begin
            if (bus.flush_i) begin
               cnt_d = '0;
            end else begin
               sweep_we = 1'b1;
               if (cnt_q == LAST_SET) begin
                  state_d = S_IDLE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_IDLE: begin
            if (bus.flush_i) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
            end else if (bus.hit_i || bus.miss_i) begin
               acc_we = 1'b1;
               err_d  = bus.hit_i & bus.miss_i;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   // Lowest-indexed invalid way overrides the recency policy.
   always_comb begin
      victim_sel = pol_victim;
      if (bus.valid_i != '1) begin
         for (int w = WAYS - 1; w >= 0; w--) begin
            if (!bus.valid_i[w]) victim_sel = WW'(w);
         end
      end
   end

   assign touch_way    = bus.hit_i ? bus.current_way_i : victim_sel;
   assign bus.victim_o = (state_q == S_IDLE) ? victim_sel : '0;
   assign bus.ready_o  = (state_q == S_IDLE);
   assign bus.err_o    = err_q;

   if (MODE == 0) begin : g_lru
      logic [WAYS*WW-1:0] age_mem [SETS];
      logic [WAYS*WW-1:0] row_rd, row_upd, row_init;
      logic [WW-1:0]      age_rd [WAYS];

      assign row_rd = age_mem[set_idx];

      always_comb begin
         row_init = '0;
         for (int w = 0; w < WAYS; w++) begin
            row_init[w*WW +: WW] = WW'(WAYS - 1 - w);
            age_rd[w]            = row_rd[w*WW +: WW];
         end
      end

      always_comb begin
         pol_victim = '0;
         for (int w = 0; w < WAYS; w++) begin
            if (age_rd[w] == WW'(WAYS - 1)) pol_victim = WW'(w);
         end
      end

      // Ages younger than the touched way get one older; the touched way becomes 0.
      always_comb begin
         row_upd = row_rd;
         for (int w = 0; w < WAYS; w++) begin
            if (age_rd[w] < age_rd[touch_way]) row_upd[w*WW +: WW] = age_rd[w] + 1'b1;
            if (WW'(w) == touch_way)           row_upd[w*WW +: WW] = '0;
         end
      end

      always_ff @(posedge clock) begin
         if (sweep_we)    age_mem[cnt_q]   <= row_init;
         else if (acc_we) age_mem[set_idx] <= row_upd;
      end
   end else begin : g_plru
      logic [WAYS-2:0] tree_mem [SETS];
      logic [WAYS-2:0] tree_rd, tree_upd;

      assign tree_rd = tree_mem[set_idx];

      // Heap-ordered tree: node n has children 2n+1 (left, bit 0) and 2n+2 (right, bit 1).
      always_comb begin
         int   node;
         logic b;
         pol_victim = '0;
         node       = 0;
         for (int l = 0; l < WW; l++) begin
            b = 1'b0;
            for (int n = 0; n < WAYS - 1; n++) begin
               if (n == node) b = tree_rd[n];
            end
            pol_victim[WW-1-l] = b;
            node = 2 * node + 1 + int'(b);
         end
      end

      always_comb begin
         int   node;
         logic dir;
         tree_upd = tree_rd;
         node     = 0;
         for (int l = 0; l < WW; l++) begin
            dir = touch_way[WW-1-l];
            for (int n = 0; n < WAYS - 1; n++) begin
               if (n == node) tree_upd[n] = ~dir;
            end
            node = 2 * node + 1 + int'(dir);
         end
      end

      always_ff @(posedge clock) begin
         if (sweep_we)    tree_mem[cnt_q]   <= '0;
         else if (acc_we) tree_mem[set_idx] <= tree_upd;
      end
   end
endmodule

// File: tb/tb_cache_replace_policy.sv
// Directed bench for cache_replace_policy: an LRU instance checked against a recency-list
// model and a PLRU instance checked against hand-derived victims, via an expectation queue.
module tb_cache_replace_policy;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   cache_replace_policy_if #(.ADDR_WIDTH(32), .WAYS(4)) b0 ();
   cache_replace_policy_if #(.ADDR_WIDTH(32), .WAYS(4)) b1 ();

   cache_replace_policy #(.MODE(0)) u_lru  (.clock(clk), .rst_n(rst_n), .bus(b0.slave));
   cache_replace_policy #(.MODE(1)) u_plru (.clock(clk), .rst_n(rst_n), .bus(b1.slave));

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   order [4];

   task automatic sb_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb.push_back(e);
   endtask

   task automatic check(input logic [31:0] obs);
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
         miscompares++;
         $error("FAIL sb_empty observed=%0h expected=none", obs);
      end else begin
         e = sb.pop_front();
         assert (obs === e.val) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
         end
      end
   endtask

   // Recency list, most recent first; a fresh set has way 3 newest and way 0 oldest.
   task automatic model_reset();
      order[0] = 3; order[1] = 2; order[2] = 1; order[3] = 0;
   endtask

   task automatic model_touch(input int w);
      int pos = 0;
      for (int i = 0; i < 4; i++) if (order[i] == w) pos = i;
      for (int i = pos; i > 0; i--) order[i] = order[i-1];
      order[0] = w;
   endtask

   function automatic logic [1:0] model_victim(input logic [3:0] valid);
      if (valid != 4'hF) begin
         for (int w = 0; w < 4; w++) if (!valid[w]) return 2'(w);
      end
      return 2'(order[3]);
   endfunction

   // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
   task automatic lru_op(input logic hit, input logic miss, input logic [1:0] way, input string tag);
      logic [1:0] v;
      b0.hit_i = hit;
      b0.miss_i = miss;
      b0.current_way_i = way;
      v = model_victim(b0.valid_i);
      sb_push(tag, 32'(v));
      @(negedge clk);
      check(32'(b0.victim_o));
      @(posedge clk); #1;
      b0.hit_i = 1'b0;
      b0.miss_i = 1'b0;
      if (hit) model_touch(int'(way));
      else if (miss) model_touch(int'(v));
   endtask

   task automatic probe0(input logic [1:0] exp_v, input string tag);
      sb_push(tag, 32'(exp_v));
      @(negedge clk);
      check(32'(b0.victim_o));
      @(posedge clk); #1;
   endtask

   task automatic probe1(input logic [1:0] exp_v, input string tag);
      sb_push(tag, 32'(exp_v));
      @(negedge clk);
      check(32'(b1.victim_o));
      @(posedge clk); #1;
   endtask

   task automatic plru_hit(input logic [1:0] way);
      b1.hit_i = 1'b1;
      b1.current_way_i = way;
      @(posedge clk); #1;
      b1.hit_i = 1'b0;
   endtask

   // Counts rising edges until ready_o rises; victim_o must stay 0 while sweeping.
   task automatic wait_ready(input string tag);
      int n = 0;
      while (n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (b0.ready_o) break;
         if (n == 300) begin
            sb_push({tag, "_victim_busy"}, 32'd0);
            check(32'(b0.victim_o));
         end
      end
      b0.hit_i = 1'b0;
      b0.valid_i = 4'hF;
      sb_push(tag, 32'd512);
      check(n);
   endtask

   initial begin
      b0.addr_i = 32'habc12400; b0.valid_i = 4'hF; b0.current_way_i = '0;
      b0.hit_i = 1'b0; b0.miss_i = 1'b0; b0.flush_i = 1'b0;
      b1.addr_i = 32'habc12400; b1.valid_i = 4'hF; b1.current_way_i = '0;
      b1.hit_i = 1'b0; b1.miss_i = 1'b0; b1.flush_i = 1'b0;
      model_reset();

      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sb_push("rst_ready", 32'd0);  check(32'(b0.ready_o));
      sb_push("rst_victim", 32'd0); check(32'(b0.victim_o));
      sb_push("rst_err", 32'd0);    check(32'(b0.err_o));
      rst_n = 1'b1;
      wait_ready("init_edges");
      sb_push("plru_ready", 32'd1); check(32'(b1.ready_o));

      probe0(2'd0, "fresh_victim");
      for (int w = 0; w < 4; w++) lru_op(1'b1, 1'b0, 2'(w), "hit_seq");
      probe0(2'd0, "after_hits_0123");
      lru_op(1'b1, 1'b0, 2'd0, "hit0");
      probe0(2'd1, "after_hit0");
      sb_push("no_err_after_hit", 32'd0); check(32'(b0.err_o));
      lru_op(1'b0, 1'b1, 2'd3, "miss");
      probe0(2'd2, "after_miss");

      b0.valid_i = 4'b1011;
      probe0(2'd2, "invalid_pref");
      lru_op(1'b0, 1'b1, 2'd0, "miss_fill2");
      b0.valid_i = 4'hF;
      probe0(2'd3, "after_fill2");

      lru_op(1'b1, 1'b1, 2'd3, "hit_and_miss");
      sb_push("err_pulse", 32'd1); check(32'(b0.err_o));
      @(posedge clk); #1;
      sb_push("err_clear", 32'd0); check(32'(b0.err_o));
      probe0(2'd0, "way3_mru");
      repeat (3) @(posedge clk);
      #1;
      probe0(2'd0, "idle_no_change");

      for (int i = 0; i < 24; i++) begin
         b0.valid_i = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         if ($urandom_range(0, 1) == 0) lru_op(1'b1, 1'b0, 2'($urandom_range(0, 3)), "rand_hit");
         else                           lru_op(1'b0, 1'b1, 2'($urandom_range(0, 3)), "rand_miss");
      end
      b0.valid_i = 4'hF;

      lru_op(1'b1, 1'b0, 2'd3, "t6_hit3");
      b0.addr_i = 32'haaaa0000;
      probe0(2'd0, "set0_untouched");
      b0.addr_i = 32'habc12400;

      b0.flush_i = 1'b1; b0.hit_i = 1'b1; b0.current_way_i = 2'd1;
      @(posedge clk); #1;
      b0.flush_i = 1'b0;
      b0.valid_i = 4'b0111;
      wait_ready("flush_edges");
      model_reset();
      probe0(2'd0, "post_flush_victim");
      lru_op(1'b1, 1'b0, 2'd0, "post_flush_hit0");
      probe0(2'd1, "post_flush_after_hit0");

      b0.flush_i = 1'b1;
      @(posedge clk); #1;
      b0.flush_i = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      b0.flush_i = 1'b1;
      @(posedge clk); #1;
      b0.flush_i = 1'b0;
      wait_ready("reflush_edges");
      model_reset();

      b0.flush_i = 1'b1;
      @(posedge clk); #1;
      b0.flush_i = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      sb_push("midflush_rst_ready", 32'd0); check(32'(b0.ready_o));
      @(posedge clk); #1;
      rst_n = 1'b1;
      wait_ready("rst_midflush_edges");
      sb_push("plru_ready2", 32'd1); check(32'(b1.ready_o));
      lru_op(1'b1, 1'b0, 2'd2, "post_rst_hit2");

      probe1(2'd0, "plru_fresh");
      plru_hit(2'd0);
      plru_hit(2'd2);
      probe1(2'd1, "plru_after_0_2");
      plru_hit(2'd1);
      probe1(2'd3, "plru_after_1");
      b1.valid_i = 4'b1011;
      probe1(2'd2, "plru_invalid_pref");
      b1.valid_i = 4'hF;
      b1.addr_i = 32'haaaa0000;
      probe1(2'd0, "plru_set0_fresh");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
